// File: rtl/digit_blink_ctrl.sv
// digit_blink_ctrl: per-group digit enable/blink, alarm LED and counted hourly chime flash
module digit_blink_ctrl #(
  parameter int GROUPS         = 3,
  parameter int DIGITS_PER_GRP = 2,
  parameter int BLINK_CNT      = 5_000_000,
  parameter int CNT_W          = 23,
  parameter int HOURLY_FLASHES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [2*GROUPS-1:0]              grp_mode,
  input  logic                             edit_restart,
  input  logic                             hourly_trig,
  input  logic                             alarm,
  output logic [GROUPS*DIGITS_PER_GRP-1:0] digit_en,
  output logic                             led_hourly,
  output logic                             led_alarm,
  output logic                             blink_phase,
  output logic                             chime_busy
);
  localparam int TW = $clog2(2*HOURLY_FLASHES);
  typedef enum logic {IDLE, FLASH} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic led_nx, wrap, tick;
  logic [GROUPS*DIGITS_PER_GRP-1:0] en_nx;
  assign wrap = cnt == CNT_W'(BLINK_CNT-1);
  assign tick = wrap && !edit_restart;
  assign chime_busy = state == FLASH;
  for (genvar g = 0; g < GROUPS; g++) begin : grp
    logic [1:0] m;
    logic v;
    assign m = grp_mode[2*g+:2];
    assign v = m[1] ? (m[0] ? ~blink_phase : blink_phase) : m[0];
    for (genvar d = 0; d < DIGITS_PER_GRP; d++) begin : dig
      assign en_nx[g*DIGITS_PER_GRP+d] = v;
    end
  end
  always_comb begin
    state_nx = state;
    led_nx   = led_hourly;
    tcnt_nx  = tcnt;
    if (hourly_trig) begin
      state_nx = FLASH;
      led_nx   = 1'b1;
      tcnt_nx  = '0;
    end else if (state == FLASH && tick) begin
      state_nx = tcnt == TW'(2*HOURLY_FLASHES-2) ? IDLE : FLASH;
      led_nx   = tcnt == TW'(2*HOURLY_FLASHES-2) ? 1'b0 : ~led_hourly;
      tcnt_nx  = tcnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      blink_phase <= 1'b1;
      digit_en    <= '1;
      led_alarm   <= 1'b0;
      led_hourly  <= 1'b0;
      tcnt        <= '0;
      state       <= IDLE;
    end else begin
      cnt         <= (edit_restart || wrap) ? '0 : cnt + 1'b1;
      blink_phase <= edit_restart ? 1'b1 : tick ? ~blink_phase : blink_phase;
      digit_en    <= en_nx;
      led_alarm   <= alarm & blink_phase;
      led_hourly  <= led_nx;
      tcnt        <= tcnt_nx;
      state       <= state_nx;
    end
  end
endmodule
